// File: rtl/n_bit_rcpa_if.sv
// Operand/result bundle for the registered RCPA approximate adder.
interface n_bit_rcpa_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] sum;
   logic         fn;
   logic [N-1:0] exact_sum;
   logic         err_flag;
   logic         out_valid;

   // Producer side: drives operands, observes results
   modport master (
      output in_valid, a, b,
      input  sum, fn, exact_sum, err_flag, out_valid
   );

   // Adder side: consumes operands, drives results
   modport slave (
      input  in_valid, a, b,
      output sum, fn, exact_sum, err_flag, out_valid
   );
endinterface

// File: rtl/n_bit_rcpa.sv
// N-bit approximate adder: K low bits use a reverse-carry (RCPA) cell,
// the upper bits form an exact ripple-carry adder. One register stage,
// with an exact reference sum and an error flag for accuracy studies.
module n_bit_rcpa #(
   parameter int N    = 8,
   parameter int K    = N / 2,
   parameter int MODE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   n_bit_rcpa_if.slave  bus
);

   // Unsupported MODE values fall back to the MODE 1 cell
   localparam int MODE_EFF = ((MODE == 2) || (MODE == 3)) ? MODE : 1;

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   r;
   logic         c_k;
   logic         c;
   logic [N-1:0] sum_d;
   logic         fn_d;
   logic [N:0]   exact_d;
   logic         err_d;

   logic [N-1:0] sum_q;
   logic         fn_q;
   logic [N-1:0] exact_sum_q;
   logic         err_flag_q;
   logic         out_valid_q;

   // Combinational approximate sum, exact reference and error detection
   always_comb begin
      g       = bus.a & bus.b;
      p       = bus.a ^ bus.b;
      r       = '0;
      sum_d   = '0;
      c_k     = 1'b0;

      // Reverse carry runs from bit K-1 down to bit 0; r[K] stays 0
      for (int i = N - 1; i >= 0; i--) begin
         if (i < K) begin
            case (MODE_EFF)
               2: begin
                  sum_d[i] = p[i] | r[i+1];
                  r[i]     = g[i] | (p[i] & r[i+1]);
               end
               3: begin
                  sum_d[i] = (bus.a[i] | bus.b[i]) | r[i+1];
                  r[i]     = g[i];
               end
               default: begin
                  sum_d[i] = p[i] ^ r[i+1];
                  r[i]     = g[i] | (p[i] & r[i+1]);
               end
            endcase
         end
      end

      // Carry into the exact part is the generate of the top approximate bit
      for (int i = 0; i < N; i++) begin
         if (i == K - 1) begin
            c_k = g[i];
         end
      end

      // Exact ripple-carry section; with K = N this leaves fn = g[N-1]
      c = c_k;
      for (int i = 0; i < N; i++) begin
         if (i >= K) begin
            sum_d[i] = p[i] ^ c;
            c        = g[i] | (p[i] & c);
         end
      end
      fn_d = c;

      exact_d = {1'b0, bus.a} + {1'b0, bus.b};
      err_d   = ({fn_d, sum_d} != exact_d);
   end

   // Result register: reset clears everything, otherwise capture on valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q       <= '0;
         fn_q        <= 1'b0;
         exact_sum_q <= '0;
         err_flag_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            sum_q       <= sum_d;
            fn_q        <= fn_d;
            exact_sum_q <= exact_d[N-1:0];
            err_flag_q  <= err_d;
         end
      end
   end

   assign bus.sum       = sum_q;
   assign bus.fn        = fn_q;
   assign bus.exact_sum = exact_sum_q;
   assign bus.err_flag  = err_flag_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_n_bit_rcpa.sv
// Self-checking bench for n_bit_rcpa: five instances (K=4 in each MODE,
// K=0, K=8) share one stimulus stream and are scored against an
// arithmetic reference model.
module tb_n_bit_rcpa;

   localparam int NN = 8;
   localparam int ND = 5;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   // Per-instance configuration
   int kk [ND] = '{4, 4, 4, 0, 8};
   int mm [ND] = '{1, 2, 3, 1, 2};

   n_bit_rcpa_if #(.N(NN)) bus0 ();
   n_bit_rcpa_if #(.N(NN)) bus1 ();
   n_bit_rcpa_if #(.N(NN)) bus2 ();
   n_bit_rcpa_if #(.N(NN)) bus3 ();
   n_bit_rcpa_if #(.N(NN)) bus4 ();

   n_bit_rcpa #(.N(NN), .K(4), .MODE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   n_bit_rcpa #(.N(NN), .K(4), .MODE(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   n_bit_rcpa #(.N(NN), .K(4), .MODE(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   n_bit_rcpa #(.N(NN), .K(0), .MODE(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   n_bit_rcpa #(.N(NN), .K(8), .MODE(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   logic [NN-1:0] o_sum [ND];
   logic          o_fn  [ND];
   logic [NN-1:0] o_ex  [ND];
   logic          o_err [ND];
   logic          o_ov  [ND];

   assign o_sum[0] = bus0.sum; assign o_fn[0] = bus0.fn; assign o_ex[0] = bus0.exact_sum;
   assign o_err[0] = bus0.err_flag; assign o_ov[0] = bus0.out_valid;
   assign o_sum[1] = bus1.sum; assign o_fn[1] = bus1.fn; assign o_ex[1] = bus1.exact_sum;
   assign o_err[1] = bus1.err_flag; assign o_ov[1] = bus1.out_valid;
   assign o_sum[2] = bus2.sum; assign o_fn[2] = bus2.fn; assign o_ex[2] = bus2.exact_sum;
   assign o_err[2] = bus2.err_flag; assign o_ov[2] = bus2.out_valid;
   assign o_sum[3] = bus3.sum; assign o_fn[3] = bus3.fn; assign o_ex[3] = bus3.exact_sum;
   assign o_err[3] = bus3.err_flag; assign o_ov[3] = bus3.out_valid;
   assign o_sum[4] = bus4.sum; assign o_fn[4] = bus4.fn; assign o_ex[4] = bus4.exact_sum;
   assign o_err[4] = bus4.err_flag; assign o_ov[4] = bus4.out_valid;

   // Expected register contents, one set per instance
   int unsigned e_sum [ND];
   int unsigned e_fn  [ND];
   int unsigned e_ex  [ND];
   int unsigned e_err [ND];
   int unsigned e_ov  [ND];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reverse the low k bits of x
   function automatic int unsigned rev(input int unsigned x, input int k);
      int unsigned y;
      y = 0;
      for (int i = 0; i < k; i++) begin
         y = (y << 1) | ((x >> i) & 1);
      end
      return y;
   endfunction

   // Reference: reverse-carry addition is ordinary addition on bit-reversed
   // low fields; the upper field is plain integer addition.
   task automatic model(input int unsigned av, input int unsigned bv,
                        input int k, input int mode,
                        output int unsigned s, output int unsigned f,
                        output int unsigned ex, output int unsigned er);
      int unsigned mask, al, bl, low, t, cv, ck, hi, full;
      mask = (32'd1 << k) - 1;
      al   = av & mask;
      bl   = bv & mask;
      if (mode == 3) begin
         low = ((al | bl) | ((al & bl) >> 1)) & mask;
      end else if (mode == 2) begin
         t   = rev(al, k) + rev(bl, k);
         cv  = (t ^ rev(al, k) ^ rev(bl, k)) & mask;
         low = rev(cv, k) | (al ^ bl);
      end else begin
         low = rev((rev(al, k) + rev(bl, k)) & mask, k);
      end
      ck   = (k > 0) ? (((av >> (k - 1)) & (bv >> (k - 1))) & 1) : 0;
      hi   = (av >> k) + (bv >> k) + ck;
      full = (hi << k) | low;
      s    = full & 32'hFF;
      f    = (hi >> (NN - k)) & 1;
      ex   = (av + bv) & 32'hFF;
      er   = (((f << NN) | s) != (av + bv)) ? 1 : 0;
   endtask

   task automatic chk(input string tag, input int d,
                      input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus, update the scoreboard, compare all outputs
   task automatic step(input logic [NN-1:0] av, input logic [NN-1:0] bv,
                       input logic v, input logic rn);
      int unsigned s, f, ex, er;
      rst_n = rn;
      bus0.a = av; bus0.b = bv; bus0.in_valid = v;
      bus1.a = av; bus1.b = bv; bus1.in_valid = v;
      bus2.a = av; bus2.b = bv; bus2.in_valid = v;
      bus3.a = av; bus3.b = bv; bus3.in_valid = v;
      bus4.a = av; bus4.b = bv; bus4.in_valid = v;
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
         if (!rn) begin
            e_sum[d] = 0; e_fn[d] = 0; e_ex[d] = 0; e_err[d] = 0; e_ov[d] = 0;
         end else begin
            e_ov[d] = v;
            if (v) begin
               model(av, bv, kk[d], mm[d], s, f, ex, er);
               e_sum[d] = s; e_fn[d] = f; e_ex[d] = ex; e_err[d] = er;
            end
         end
      end
      #1;
      for (int d = 0; d < ND; d++) begin
         chk("sum", d, o_sum[d], e_sum[d]);
         chk("fn", d, o_fn[d], e_fn[d]);
         chk("exact_sum", d, o_ex[d], e_ex[d]);
         chk("err_flag", d, o_err[d], e_err[d]);
         chk("out_valid", d, o_ov[d], e_ov[d]);
      end
   endtask

   // Directed vector with hand-derived results for the three K=4 instances
   task automatic directed(input logic [NN-1:0] av, input logic [NN-1:0] bv,
                           input int unsigned s1, input int unsigned s2,
                           input int unsigned s3, input int unsigned fx,
                           input int unsigned exx, input int unsigned erx);
      int unsigned sx [3];
      step(av, bv, 1'b1, 1'b1);
      sx[0] = s1; sx[1] = s2; sx[2] = s3;
      for (int d = 0; d < 3; d++) begin
         chk("plan_sum", d, o_sum[d], sx[d]);
         chk("plan_fn", d, o_fn[d], fx);
         chk("plan_exact", d, o_ex[d], exx);
         chk("plan_err", d, o_err[d], erx);
         chk("plan_ov", d, o_ov[d], 1);
      end
   endtask

   initial begin
      logic [NN-1:0] ra, rb;
      checks   = 0;
      failures = 0;

      // Reset state
      step(8'h00, 8'h00, 1'b0, 1'b0);
      step(8'h5A, 8'hA5, 1'b1, 1'b0);

      // Test-plan vectors
      directed(8'h32, 8'h01, 8'h33, 8'h33, 8'h33, 0, 8'h33, 0);
      directed(8'h67, 8'h61, 8'hC6, 8'hC6, 8'hC7, 0, 8'hC8, 1);
      directed(8'h08, 8'h08, 8'h14, 8'h14, 8'h1C, 0, 8'h10, 1);
      directed(8'hFF, 8'h01, 8'hFE, 8'hFE, 8'hFF, 0, 8'h00, 1);
      directed(8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 1, 8'h00, 0);

      // Hold with in_valid low, operands changing underneath
      step(8'h3C, 8'hC3, 1'b1, 1'b1);
      step(8'hFF, 8'hFF, 1'b0, 1'b1);
      step(8'h11, 8'h77, 1'b0, 1'b1);

      // Reset mid-stream has priority over in_valid
      step(8'hAB, 8'hCD, 1'b1, 1'b1);
      step(8'h99, 8'h66, 1'b1, 1'b0);
      step(8'h99, 8'h66, 1'b0, 1'b1);

      // Extremes
      step(8'hFF, 8'hFF, 1'b1, 1'b1);
      step(8'h00, 8'h00, 1'b1, 1'b1);
      step(8'h0F, 8'h0F, 1'b1, 1'b1);
      step(8'hF0, 8'h0F, 1'b1, 1'b1);

      // Random back-to-back traffic with occasional idle cycles
      for (int n = 0; n < 200; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         step(ra, rb, ($urandom_range(0, 7) != 0), 1'b1);
         chk("k0_err", 3, o_err[3], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/n_bit_rcpa.md
Name: n_bit_rcpa

Overview:
- Parameterised N-bit approximate adder built on a reverse-carry-propagate (RCPA) lower part, registered for use in a synchronous datapath.
- Bits 0..K-1 use an approximate cell whose carry travels from higher bits toward lower bits. Bits K..N-1 form an exact ripple-carry adder.
- MODE selects one of three RCPA cell variants.
- An exact reference sum and an error flag are produced alongside, to support accuracy characterisation.

Parameters:
- N, 8: operand and sum width; N >= 2.
- K, N/2: number of approximate low bits; 0 <= K <= N. K = 0 gives a fully exact adder.
- MODE, 1: RCPA cell variant, 1, 2 or 3. Any other value behaves as 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- a  input  N  operand A, unsigned.
- b  input  N  operand B, unsigned.
- sum  output  N  registered approximate sum.
- fn  output  1  registered approximate carry-out.
- exact_sum  output  N  registered exact (a+b) mod 2^N.
- err_flag  output  1  registered; 1 when {fn,sum} differs from the exact N+1-bit result.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, all outputs go to 0. This has priority over in_valid.
- Per-bit signals, combinational: g_i = a_i & b_i, p_i = a_i ^ b_i.
- Reverse carry r runs from bit K-1 down to bit 0. r_K = 0.
  - MODE 1: s_i = p_i ^ r_{i+1}; r_i = g_i | (p_i & r_{i+1}).
  - MODE 2: s_i = p_i | r_{i+1}; r_i = g_i | (p_i & r_{i+1}).
  - MODE 3: s_i = (a_i | b_i) | r_{i+1}; r_i = g_i.
  - r_0 is discarded.
- Carry into the exact part: c_K = g_{K-1} when K > 0, otherwise 0.
- Exact part, bits K..N-1: standard ripple full adders. s_i = p_i ^ c_i; c_{i+1} = g_i | (p_i & c_i).
- fn = c_N. When K = N, fn = g_{N-1}.
- Exact reference: {ex_c, exact_sum} = a + b, computed at N+1 bits.
- err_flag = ({fn, s} != {ex_c, exact}).
- Latency is 1 cycle. When in_valid=1 at an edge, sum, fn, exact_sum and err_flag capture the combinational results. out_valid <= in_valid every cycle.
- When in_valid=0, sum, fn, exact_sum and err_flag hold their previous values.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- Wrap-around: the sum is modulo 2^N and overflow appears only on fn.
- If reset is asserted mid-stream, the in-flight result is lost and out_valid=0 on the next cycle.
- All arithmetic is unsigned, with no sign extension.

Test Plan:
- Defaults N=8, K=4 unless noted. Every check is made one cycle after the in_valid pulse.
- a=0x32, b=0x01, all MODEs -> sum=0x33, fn=0, exact_sum=0x33, err_flag=0, out_valid=1.
- a=0x67, b=0x61 -> exact_sum=0xC8 for all MODEs.
  - MODE 1: sum=0xC6, fn=0, err_flag=1.
  - MODE 2: sum=0xC6, fn=0, err_flag=1.
  - MODE 3: sum=0xC7, fn=0, err_flag=1.
- a=0x08, b=0x08 -> exact_sum=0x10 for all MODEs.
  - MODE 1: sum=0x14.
  - MODE 2: sum=0x14.
  - MODE 3: sum=0x1C.
  - fn=0 and err_flag=1 in every MODE.
- a=0xFF, b=0x01 -> exact_sum=0x00, err_flag=1 for all MODEs.
  - MODE 1/2: sum=0xFE, fn=0.
  - MODE 3: sum=0xFF, fn=0.
- a=0x80, b=0x80, all MODEs -> sum=0x00, fn=1, exact_sum=0x00, err_flag=0.
- Control and corner checks:
  - rst_n=0 while in_valid=1 -> all outputs 0 on the next edge.
  - in_valid=0 -> outputs hold and out_valid=0.
  - K=0 -> err_flag stays 0 across random operands.
